bcd_scan_counter: RTL and testbench
===================================

Name: bcd_scan_counter

Overview:
- Multi-digit BCD up/down counter with a time-multiplexed display scanner.
- Sits directly upstream of the 7-segment decoder in the counter display path. It drives the decoder's 4-bit digit code and active-low enable, and drives the active-low digit-select lines of the multiplexed display.
- Count rate and scan rate each come from an internal prescaler off the single system clock.

Parameters:
- DIGITS, 2: number of BCD decades; the counter holds 0 .. 10^DIGITS-1.
- TICK_DIV, 50_000_000: clock cycles per count tick; must be >= 2.
- SCAN_DIV, 50_000: clock cycles per digit-scan step; must be >= 2.
- BLANK, 1: 1 enables leading-zero blanking; 0 always shows every digit.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  asynchronous active-low reset.
- en  in  1  count enable; gates tick generation only.
- up  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_val  in  4*DIGITS  BCD load value; nibble 0 is the least-significant digit.
- bcd  out  4*DIGITS  current count, BCD.
- co  out  1  one-cycle pulse on wrap: 99..9 to 0 when counting up, 0 to 99..9 when counting down.
- digit  out  4  BCD code of the scanned digit, to the decoder.
- n_en_out  out  1  active-low enable to the decoder; 1 blanks the digit.
- dig_sel  out  DIGITS  one-hot active-low select of the scanned digit.

Behaviour:
- Reset is asynchronous and active-low (n_rst=0). Reset values:
  - bcd = 0, co = 0.
  - Tick and scan prescalers = 0; scan index = 0.
  - digit = 0, n_en_out = 0, dig_sel = all ones except bit 0 low.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 while en=1, then wraps.
  - tick asserts for the cycle in which the prescaler equals TICK_DIV-1 and en=1.
  - en=0 holds the prescaler value.
  - clr resets the prescaler to 0; load does not.
- Count update priority each cycle: clr > load > tick.
  - clr: bcd = 0, co = 0.
  - load: each nibble takes its load_val nibble; any nibble > 9 is loaded as 0; co = 0.
  - tick with up=1: ripple-carry BCD increment. Each digit goes 9 to 0 and carries. All-nines goes to 0 and sets co = 1 for exactly one cycle.
  - tick with up=0: ripple-borrow decrement. Each digit goes 0 to 9 and borrows. All-zeros goes to all-nines and sets co = 1 for one cycle.
  - Otherwise bcd holds and co = 0.
- bcd is registered: it changes on the edge that ends the tick cycle. co is asserted in the cycle after that tick, coincident with the wrapped bcd value.
- Scan:
  - The scan prescaler counts 0..SCAN_DIV-1 continuously, independent of en, clr and load.
  - At SCAN_DIV-1 the scan index advances 0 to DIGITS-1, then wraps to 0.
- Display outputs are registered from the current index and bcd, with 1-cycle latency:
  - digit = bcd nibble[index].
  - dig_sel[index] = 0; all other bits = 1.
  - n_en_out = 1 only if BLANK=1, index > 0, and every nibble from index up to DIGITS-1 is 0. Digit 0 is never blanked, so a count of 0 shows a single "0".
- A load or count change mid-scan takes effect on the next registered display update; there is no tearing within a digit slot.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous). Counting resumes from 0 after release.
- Nibbles are stored as 4-bit values that are always in the range 0-9. An out-of-range nibble is unreachable except through load, which sanitises it.

Decomposition:
- Shared package `counter_pkg`:
  - Constant BCD_MAX = 4'd9.
  - Function `bcd_sanitise` (nibble > 9 gives 0).
  - Default-divider constants for board (50 MHz) and simulation.
- Sub-module `bcd_digit`: one decade. Inputs: clr, load, load nibble, step, up, carry/borrow in. Outputs: nibble, carry/borrow out. Instantiated DIGITS times in a ripple chain.
- Prescalers and the scan mux stay in the top module.

Test Plan (all with TICK_DIV=4, SCAN_DIV=3, DIGITS=2, BLANK=1):
1. Reset: hold n_rst=0 mid-count -> bcd=8'h00, co=0, dig_sel=2'b10, digit=0, n_en_out=0 asynchronously, before any clock edge.
2. Up count: en=1, up=1, load 8'h98 -> ticks every 4 cycles give 98, 99, 00. co pulses high for exactly 1 cycle together with 00, then 01.
3. Down count: load 8'h01, up=0 -> 01, 00, 99. co pulses 1 cycle with 99. Then 98.
4. Priority: assert clr and load (8'h55) in the same cycle as a tick -> bcd=00. Next cycle load only -> 55. load_val 8'hA7 -> bcd=07.
5. Scan and blanking at bcd=07: digit slot 0 -> digit=7, dig_sel=10, n_en_out=0. Slot 1 -> dig_sel=01, n_en_out=1. Slots alternate every 3 cycles with a 1-cycle output lag. At bcd=00: slot 0 shows 0, unblanked.
6. Enable gating: en=0 for 10 cycles at bcd=42 -> bcd holds and scan keeps running. On en=1 the next tick arrives at the remaining prescaler distance, not a full TICK_DIV.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the BCD counter display path.
package counter_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Divider defaults: 50 MHz board clock and a fast simulation setting.
    localparam int unsigned TICK_DIV_BOARD = 50_000_000;
    localparam int unsigned SCAN_DIV_BOARD = 50_000;
    localparam int unsigned TICK_DIV_SIM   = 4;
    localparam int unsigned SCAN_DIV_SIM   = 3;

    // Non-decimal nibbles collapse to zero so stored digits stay in 0..9.
    function automatic logic [3:0] bcd_sanitise(input logic [3:0] nib);
        return (nib > BCD_MAX) ? 4'd0 : nib;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with clear/load and ripple carry (up) or borrow (down).
module bcd_digit
    import counter_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_nib,
    input  logic       step,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] nib,
    output logic       cout_c
);

    logic roll_c;

    // This decade wraps when it sits at the end of its range in the count direction.
    assign roll_c = up ? (nib == BCD_MAX) : (nib == 4'd0);
    assign cout_c = step & cin & roll_c;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            nib <= 4'd0;
        end else if (clr) begin
            nib <= 4'd0;
        end else if (load) begin
            nib <= bcd_sanitise(load_nib);
        end else if (step && cin) begin
            if (up) begin
                nib <= roll_c ? 4'd0 : nib + 4'd1;
            end else begin
                nib <= roll_c ? BCD_MAX : nib - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaled tick and a multiplexed display scanner.
module bcd_scan_counter
    import counter_pkg::*;
#(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TICK_DIV = TICK_DIV_BOARD,
    parameter int unsigned SCAN_DIV = SCAN_DIV_BOARD,
    parameter bit          BLANK    = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] bcd,
    output logic                co,
    output logic [3:0]          digit,
    output logic                n_en_out,
    output logic [DIGITS-1:0]   dig_sel
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  idx;
    logic              tick_c;
    logic              scan_wrap_c;
    logic              blank_c;
    logic              upper_zero_c;
    logic [DIGITS:0]   carry;
    logic [3:0]        nib [DIGITS];

    assign tick_c      = en && (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign scan_wrap_c = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign carry[0]    = 1'b1;

    // Tick prescaler: frozen while disabled, restarted by clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .n_rst    (n_rst),
            .clr      (clr),
            .load     (load),
            .load_nib (load_val[4*g +: 4]),
            .step     (tick_c),
            .up       (up),
            .cin      (carry[g]),
            .nib      (nib[g]),
            .cout_c   (carry[g+1])
        );
        assign bcd[4*g +: 4] = nib[g];
    end

    // Carry out of the top decade only counts when no clear/load overrides the tick.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            co <= 1'b0;
        end else begin
            co <= carry[DIGITS] & ~clr & ~load;
        end
    end

    // Free-running scan prescaler and digit index.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_wrap_c) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Blank the scanned digit when it and every more-significant digit are zero.
    always_comb begin
        blank_c      = 1'b0;
        upper_zero_c = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (nib[i] != 4'd0) begin
                upper_zero_c = 1'b0;
            end
            if (IDX_W'(i) == idx) begin
                blank_c = BLANK && (i != 0) && upper_zero_c;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            digit    <= 4'd0;
            n_en_out <= 1'b0;
            dig_sel  <= ~DIGITS'(1);
        end else begin
            digit    <= nib[idx];
            n_en_out <= blank_c;
            dig_sel  <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench: arithmetic reference model plus directed literal checks.
module tb_bcd_scan_counter;

    localparam int unsigned TD = 4;
    localparam int unsigned SD = 3;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] bcd;
    logic       co;
    logic [3:0] digit;
    logic       n_en_out;
    logic [1:0] dig_sel;

    int n_cmp = 0;
    int n_err = 0;

    bcd_scan_counter #(
        .DIGITS   (2),
        .TICK_DIV (TD),
        .SCAN_DIV (SD),
        .BLANK    (1'b1)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .co       (co),
        .digit    (digit),
        .n_en_out (n_en_out),
        .dig_sel  (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Reference model: count held as a plain integer 0..99.
    int         m_val = 0;
    logic       m_co = 1'b0;
    int         m_tcnt = 0;
    int         m_scnt = 0;
    int         m_idx = 0;
    int         m_digit = 0;
    logic       m_nen = 1'b0;
    logic [1:0] m_dsel = 2'b10;

    always @(posedge clk or negedge n_rst) begin
        int pw, d0, d1;
        logic tick;
        if (!n_rst) begin
            m_val = 0; m_co = 1'b0; m_tcnt = 0; m_scnt = 0; m_idx = 0;
            m_digit = 0; m_nen = 1'b0; m_dsel = 2'b10;
        end else begin
            pw = (m_idx == 0) ? 1 : 10;
            m_digit = (m_val / pw) % 10;
            m_nen   = (m_idx > 0) && ((m_val / pw) == 0);
            m_dsel  = ~(2'b01 << m_idx);
            tick = en && (m_tcnt == TD - 1);
            if (clr) begin
                m_val = 0; m_co = 1'b0;
            end else if (load) begin
                d0 = (load_val[3:0] > 9) ? 0 : int'(load_val[3:0]);
                d1 = (load_val[7:4] > 9) ? 0 : int'(load_val[7:4]);
                m_val = d1 * 10 + d0; m_co = 1'b0;
            end else if (tick) begin
                if (up) begin
                    m_co  = (m_val == 99);
                    m_val = (m_val + 1) % 100;
                end else begin
                    m_co  = (m_val == 0);
                    m_val = (m_val + 99) % 100;
                end
            end else begin
                m_co = 1'b0;
            end
            if (clr) m_tcnt = 0;
            else if (en) m_tcnt = (m_tcnt + 1) % TD;
            if (m_scnt == SD - 1) begin
                m_scnt = 0;
                m_idx  = (m_idx + 1) % 2;
            end else begin
                m_scnt = m_scnt + 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (n_rst) begin
            chk("model_bcd", bcd, to_bcd(m_val));
            chk("model_co", co, m_co);
            chk("model_digit", digit, m_digit);
            chk("model_n_en_out", n_en_out, m_nen);
            chk("model_dig_sel", dig_sel, m_dsel);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_val(input string name, input logic [7:0] target);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bcd == target) break;
        end
        chk(name, bcd, target);
    endtask

    task automatic wait_sel(input string name, input logic [1:0] target);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dig_sel == target) break;
        end
        chk(name, dig_sel, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        // Reset, then count a little and reset mid-cycle.
        repeat (2) cyc();
        n_rst = 1'b1;
        en = 1'b1; up = 1'b1;
        repeat (10) cyc();
        chk("pre_reset_bcd", bcd, 8'h02);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_bcd", bcd, 8'h00);
        chk("rst_co", co, 1'b0);
        chk("rst_dig_sel", dig_sel, 2'b10);
        chk("rst_digit", digit, 4'd0);
        chk("rst_n_en_out", n_en_out, 1'b0);
        cyc();
        n_rst = 1'b1;

        // Up count across the wrap.
        load = 1'b1; load_val = 8'h98;
        cyc();
        load = 1'b0;
        chk("load_98", bcd, 8'h98);
        wait_val("up_99", 8'h99);
        wait_val("up_00", 8'h00);
        chk("up_wrap_co", co, 1'b1);
        @(negedge clk);
        chk("up_co_one_cycle", co, 1'b0);
        wait_val("up_01", 8'h01);

        // Down count across the wrap.
        up = 1'b0;
        load = 1'b1; load_val = 8'h01;
        cyc();
        load = 1'b0;
        wait_val("dn_00", 8'h00);
        chk("dn_00_co", co, 1'b0);
        wait_val("dn_99", 8'h99);
        chk("dn_wrap_co", co, 1'b1);
        @(negedge clk);
        chk("dn_co_one_cycle", co, 1'b0);
        wait_val("dn_98", 8'h98);

        // clr beats load beats tick.
        up = 1'b1;
        for (int i = 0; i < 10 && m_tcnt != TD - 1; i++) cyc();
        clr = 1'b1; load = 1'b1; load_val = 8'h55;
        cyc();
        chk("prio_clr", bcd, 8'h00);
        clr = 1'b0;
        cyc();
        chk("prio_load", bcd, 8'h55);
        load_val = 8'hA7;
        cyc();
        chk("load_sanitise", bcd, 8'h07);
        load = 1'b0; en = 1'b0;

        // Scan and blanking at 07, then 00.
        wait_sel("scan07_slot0", 2'b10);
        chk("scan07_digit0", digit, 4'd7);
        chk("scan07_nen0", n_en_out, 1'b0);
        wait_sel("scan07_slot1", 2'b01);
        chk("scan07_nen1", n_en_out, 1'b1);
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (8) cyc();
        wait_sel("scan00_slot0", 2'b10);
        chk("scan00_digit0", digit, 4'd0);
        chk("scan00_nen0", n_en_out, 1'b0);

        // Enable gating: prescaler is 0 after clr; advance two, pause, resume.
        load = 1'b1; load_val = 8'h42;
        cyc();
        load = 1'b0;
        en = 1'b1;
        repeat (2) cyc();
        en = 1'b0;
        repeat (10) cyc();
        chk("gate_hold", bcd, 8'h42);
        en = 1'b1;
        edges = 0;
        for (int i = 0; i < 10 && bcd == 8'h42; i++) begin
            cyc();
            edges++;
        end
        chk("gate_bcd", bcd, 8'h43);
        chk("gate_resume_edges", 32'(edges), 32'd2);
        repeat (6) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
